// File: rtl/exception_sequencer_pkg.sv
// ==== mips_ctrl_pkg : shared exception-control types and constants ====
// ==== rev 1.0 ====
`default_nettype none

package mips_ctrl_pkg;

  localparam int CAUSE_INVOP = 0;
  localparam int CAUSE_OVF   = 1;
  localparam int CAUSE_DIVZ  = 2;

  localparam logic [31:0] DEF_VEC_BASE = 32'd253;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_ADDR    = 3'd2,
    S_WAIT    = 3'd3,
    S_LOAD    = 3'd4,
    S_DONE    = 3'd5
  } exc_state_t;

  // Cause index width, never below one bit even for a single cause.
  function automatic int cause_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/exception_sequencer_if.sv
// ==== exception_sequencer_if : request/memory/PC bundle of the sequencer ====
// ==== rev 1.0 ====
`default_nettype none

interface exception_sequencer_if
  import mips_ctrl_pkg::*;
#(
  parameter int NUM_CAUSES = 3,
  parameter int DATA_W     = 32
);

  localparam int CAUSE_W = cause_width(NUM_CAUSES);

  logic [NUM_CAUSES-1:0] exc_req;
  logic [DATA_W-1:0]     pc_in;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  busy;
  logic                  done;
  logic [CAUSE_W-1:0]    cause;
  logic                  epc_write;
  logic [DATA_W-1:0]     epc_value;
  logic                  mem_rd;
  logic [DATA_W-1:0]     mem_addr;
  logic                  pc_write;
  logic [DATA_W-1:0]     pc_value;

  modport master (
    output exc_req, pc_in, mem_rdata,
    input  busy, done, cause, epc_write, epc_value,
    input  mem_rd, mem_addr, pc_write, pc_value
  );

  modport slave (
    input  exc_req, pc_in, mem_rdata,
    output busy, done, cause, epc_write, epc_value,
    output mem_rd, mem_addr, pc_write, pc_value
  );

endinterface

`default_nettype wire

// File: rtl/exception_sequencer_prio_enc.sv
// ==== exc_prio_enc : lowest-index-wins priority encoder with valid ====
// ==== rev 1.0 ====
`default_nettype none

module exc_prio_enc #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scan downwards so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/exception_sequencer.sv
// ==== exception_sequencer : EPC save, vector fetch and PC load on exceptions ====
// ==== rev 1.0 ====
`default_nettype none

module exception_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int                NUM_CAUSES = 3,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] VEC_BASE   = DATA_W'(DEF_VEC_BASE),
  parameter int                MEM_LAT    = 1
) (
  input  logic                  clck,
  input  logic                  reset,
  exception_sequencer_if.slave  bus
);

  localparam int CAUSE_W = cause_width(NUM_CAUSES);

  exc_state_t          state_q, state_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic [DATA_W-1:0]   epc_q, epc_d;
  logic [DATA_W-1:0]   pcv_q, pcv_d;
  logic [3:0]          wait_q, wait_d;

  logic [CAUSE_W-1:0]  w_prio_idx;
  logic                w_prio_vld;
  logic                w_mem_rd;
  logic [DATA_W-1:0]   w_vec_addr;

  exc_prio_enc #(
    .N (NUM_CAUSES),
    .W (CAUSE_W)
  ) u_prio (
    .req_i   (bus.exc_req),
    .idx_o   (w_prio_idx),
    .valid_o (w_prio_vld)
  );

  always_ff @(posedge clck) begin
    if (reset) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      pcv_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      pcv_q   <= pcv_d;
      wait_q  <= wait_d;
    end
  end

  // EPC is formed at the accept edge so it is already valid in CAPTURE
  // and reads as zero straight out of reset.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    pcv_d   = pcv_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (w_prio_vld) begin
          cause_d = w_prio_idx;
          epc_d   = bus.pc_in - DATA_W'(4);
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: state_d = S_ADDR;
      S_ADDR: begin
        if (MEM_LAT == 0) begin
          pcv_d   = DATA_W'(bus.mem_rdata[7:0]);
          state_d = S_LOAD;
        end else begin
          wait_d  = 4'(MEM_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) begin
          pcv_d   = DATA_W'(bus.mem_rdata[7:0]);
          state_d = S_LOAD;
        end else begin
          wait_d  = wait_q - 4'd1;
        end
      end
      S_LOAD:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign w_mem_rd   = (state_q == S_ADDR) || (state_q == S_WAIT);
  assign w_vec_addr = VEC_BASE + DATA_W'(cause_q);

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.cause     = cause_q;
  assign bus.epc_write = (state_q == S_CAPTURE);
  assign bus.epc_value = epc_q;
  assign bus.mem_rd    = w_mem_rd;
  assign bus.mem_addr  = w_mem_rd ? w_vec_addr : '0;
  assign bus.pc_write  = (state_q == S_LOAD);
  assign bus.pc_value  = pcv_q;

endmodule

`default_nettype wire

// File: tb/tb_exception_sequencer.sv
// ==== tb_exception_sequencer : directed checks of the exception sequencer ====
// ==== rev 1.0 ====
`default_nettype none

module tb_exception_sequencer;
  import mips_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  exc_req;
  logic [31:0] pc_in;
  logic [31:0] mem_rdata;

  int tests;
  int fails;

  exception_sequencer_if #(.NUM_CAUSES(3), .DATA_W(32)) if0 ();
  exception_sequencer_if #(.NUM_CAUSES(3), .DATA_W(32)) if1 ();
  exception_sequencer_if #(.NUM_CAUSES(3), .DATA_W(32)) if3 ();

  assign if0.exc_req = exc_req;  assign if0.pc_in = pc_in;  assign if0.mem_rdata = mem_rdata;
  assign if1.exc_req = exc_req;  assign if1.pc_in = pc_in;  assign if1.mem_rdata = mem_rdata;
  assign if3.exc_req = exc_req;  assign if3.pc_in = pc_in;  assign if3.mem_rdata = mem_rdata;

  exception_sequencer #(.NUM_CAUSES(3), .DATA_W(32), .VEC_BASE(32'd253), .MEM_LAT(0))
    u_lat0 (.clck(clk), .reset(reset), .bus(if0.slave));
  exception_sequencer #(.NUM_CAUSES(3), .DATA_W(32), .VEC_BASE(32'd253), .MEM_LAT(1))
    u_lat1 (.clck(clk), .reset(reset), .bus(if1.slave));
  exception_sequencer #(.NUM_CAUSES(3), .DATA_W(32), .VEC_BASE(32'd253), .MEM_LAT(3))
    u_lat3 (.clck(clk), .reset(reset), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_wait(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, " busy"},      32'(if1.busy),      32'd0);
    check({pfx, " done"},      32'(if1.done),      32'd0);
    check({pfx, " cause"},     32'(if1.cause),     32'd0);
    check({pfx, " epc_write"}, 32'(if1.epc_write), 32'd0);
    check({pfx, " epc_value"}, if1.epc_value,      32'd0);
    check({pfx, " mem_rd"},    32'(if1.mem_rd),    32'd0);
    check({pfx, " mem_addr"},  if1.mem_addr,       32'd0);
    check({pfx, " pc_write"},  32'(if1.pc_write),  32'd0);
    check({pfx, " pc_value"},  if1.pc_value,       32'd0);
  endtask

  initial begin
    int at0, at1, at3, cnt;
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    exc_req   = '0;
    pc_in     = '0;
    mem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    check_all_zero("rst");

    // Overflow with one wait state
    exc_req   = 3'(1 << CAUSE_OVF);
    pc_in     = 32'h0000_0020;
    mem_rdata = 32'hDEAD_BE80;
    tick();
    exc_req = '0;
    check("ovf c1 epc_write", 32'(if1.epc_write), 32'd1);
    check("ovf c1 epc_value", if1.epc_value, 32'h0000_001C);
    check("ovf c1 cause",     32'(if1.cause), 32'd1);
    check("ovf c1 busy",      32'(if1.busy), 32'd1);
    check("ovf c1 mem_rd",    32'(if1.mem_rd), 32'd0);
    tick();
    check("ovf c2 epc_write", 32'(if1.epc_write), 32'd0);
    check("ovf c2 mem_rd",    32'(if1.mem_rd), 32'd1);
    check("ovf c2 mem_addr",  if1.mem_addr, 32'd254);
    tick();
    check("ovf c3 mem_rd",    32'(if1.mem_rd), 32'd1);
    check("ovf c3 mem_addr",  if1.mem_addr, 32'd254);
    check("ovf c3 pc_write",  32'(if1.pc_write), 32'd0);
    tick();
    check("ovf c4 pc_write",  32'(if1.pc_write), 32'd1);
    check("ovf c4 pc_value",  if1.pc_value, 32'h0000_0080);
    check("ovf c4 mem_rd",    32'(if1.mem_rd), 32'd0);
    check("ovf c4 done",      32'(if1.done), 32'd0);
    tick();
    check("ovf c5 done",      32'(if1.done), 32'd1);
    check("ovf c5 busy",      32'(if1.busy), 32'd1);
    check("ovf c5 pc_write",  32'(if1.pc_write), 32'd0);
    tick();
    check("ovf c6 done",      32'(if1.done), 32'd0);
    check("ovf c6 busy",      32'(if1.busy), 32'd0);
    check("ovf c6 epc hold",  if1.epc_value, 32'h0000_001C);
    check("ovf c6 cause hold", 32'(if1.cause), 32'd1);
    check("ovf c6 pc hold",   if1.pc_value, 32'h0000_0080);
    idle_wait(4);

    // Priority: overflow beats divide-by-zero
    exc_req   = 3'b110;
    pc_in     = 32'h0000_0100;
    mem_rdata = 32'h0000_0044;
    tick();
    exc_req = '0;
    check("prio110 cause", 32'(if1.cause), 32'd1);
    tick();
    check("prio110 mem_addr", if1.mem_addr, 32'd254);
    idle_wait(8);

    // Priority: invalid opcode beats divide-by-zero
    exc_req = 3'b101;
    tick();
    exc_req = '0;
    check("prio101 cause", 32'(if1.cause), 32'd0);
    tick();
    check("prio101 mem_addr", if1.mem_addr, 32'd253);
    idle_wait(8);

    // Divide-by-zero latency across wait-state builds
    exc_req   = 3'(1 << CAUSE_DIVZ);
    pc_in     = 32'h0000_0300;
    mem_rdata = 32'h1234_565A;
    at0 = 0; at1 = 0; at3 = 0;
    tick();
    exc_req = '0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 2) begin
        check("divz lat0 mem_addr", if0.mem_addr, 32'd255);
        check("divz lat1 mem_addr", if1.mem_addr, 32'd255);
        check("divz lat3 mem_addr", if3.mem_addr, 32'd255);
      end
      if (if0.pc_write && at0 == 0) at0 = n;
      if (if1.pc_write && at1 == 0) at1 = n;
      if (if3.pc_write && at3 == 0) at3 = n;
      tick();
    end
    check("divz lat0 pc_write cycle", 32'(at0), 32'd3);
    check("divz lat1 pc_write cycle", 32'(at1), 32'd4);
    check("divz lat3 pc_write cycle", 32'(at3), 32'd6);
    check("divz lat3 pc_value", if3.pc_value, 32'h0000_005A);
    check("divz lat0 pc_value", if0.pc_value, 32'h0000_005A);
    idle_wait(2);

    // Request pulsed while in WAIT is ignored
    exc_req   = 3'(1 << CAUSE_OVF);
    pc_in     = 32'h0000_0040;
    mem_rdata = 32'h0000_0011;
    tick();
    exc_req = '0;
    tick();
    tick();
    check("busy c3 mem_rd (WAIT)", 32'(if1.mem_rd), 32'd1);
    exc_req = 3'(1 << CAUSE_INVOP);
    tick();
    exc_req = '0;
    check("busy c4 cause", 32'(if1.cause), 32'd1);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (if1.done) cnt++;
      tick();
    end
    check("busy done pulses", 32'(cnt), 32'd1);
    check("busy cause after", 32'(if1.cause), 32'd1);
    check("busy pc_value", if1.pc_value, 32'h0000_0011);

    // Reset asserted while in WAIT
    exc_req   = 3'(1 << CAUSE_DIVZ);
    pc_in     = 32'h0000_0080;
    mem_rdata = 32'h0000_0033;
    tick();
    exc_req = '0;
    tick();
    tick();
    check("rstwait mem_rd (WAIT)", 32'(if1.mem_rd), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rstwait");
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      if (if1.pc_write) cnt++;
      tick();
    end
    check("rstwait no pc_write", 32'(cnt), 32'd0);

    // Full sequence after mid-flight reset
    exc_req   = 3'(1 << CAUSE_OVF);
    pc_in     = 32'h0000_0200;
    mem_rdata = 32'h0000_0099;
    tick();
    exc_req = '0;
    check("post-rst epc_value", if1.epc_value, 32'h0000_01FC);
    tick();
    tick();
    tick();
    check("post-rst pc_write", 32'(if1.pc_write), 32'd1);
    check("post-rst pc_value", if1.pc_value, 32'h0000_0099);
    tick();
    check("post-rst done", 32'(if1.done), 32'd1);
    idle_wait(6);

    // EPC wraps below zero
    exc_req = 3'(1 << CAUSE_INVOP);
    pc_in   = 32'h0000_0000;
    tick();
    exc_req = '0;
    check("wrap epc_value", if1.epc_value, 32'hFFFF_FFFC);
    check("wrap cause", 32'(if1.cause), 32'd0);
    idle_wait(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Parametrised exception sequencer for the multicycle MIPS datapath.
- The main control FSM hands off to it on overflow, divide-by-zero or an invalid opcode, and it runs the whole exception entry:
  - saves EPC = PC-4;
  - reads a one-byte handler address from the vector table in memory, with configurable memory wait-states;
  - loads PC with that address;
  - signals done.

Parameters:
- NUM_CAUSES, 3, number of exception causes; exc_req bit i = cause i; bit 0 has highest priority.
- VEC_BASE, 32'd253, byte address of vector entry for cause 0; cause i reads VEC_BASE+i.
- MEM_LAT, 1, extra memory wait cycles after address issue (0..15).
- DATA_W, 32, PC/memory data width.

Ports:
- clck  in  1  system clock, rising-edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- exc_req  in  NUM_CAUSES  exception request bits, sampled in IDLE only.
- pc_in  in  DATA_W  current PC (already PC+4), sampled with the request.
- mem_rdata  in  DATA_W  memory read data; handler address in bits [7:0].
- busy  out  1  high from CAPTURE through DONE.
- done  out  1  one-cycle pulse in DONE.
- cause  out  CAUSE_W  latched cause index; CAUSE_W = max(1, clog2(NUM_CAUSES)).
- epc_write  out  1  EPC load strobe.
- epc_value  out  DATA_W  latched pc_in minus 4, mod 2^DATA_W.
- mem_rd  out  1  memory read enable.
- mem_addr  out  DATA_W  VEC_BASE + cause.
- pc_write  out  1  PC load strobe.
- pc_value  out  DATA_W  zero-extended handler byte.

Behaviour:
- Output style:
  - Moore outputs, decoded from the registered state plus datapath registers.
  - All outputs are 0 after reset, including epc_value, mem_addr, pc_value and cause.
- States: IDLE, CAPTURE, ADDR, WAIT, LOAD, DONE.
- IDLE:
  - If any exc_req bit is 1 at the edge, latch cause = lowest set index and latch pc_in, then go to CAPTURE.
  - If exc_req is all zero, stay in IDLE.
- CAPTURE: epc_write=1, epc_value = pc_latched-4 (wraps at 0 to all-ones minus 3); go to ADDR.
- ADDR:
  - mem_rd=1, mem_addr = VEC_BASE+cause.
  - If MEM_LAT==0: capture mem_rdata[7:0] at this edge, go to LOAD.
  - Otherwise load the wait counter with MEM_LAT-1 and go to WAIT.
- WAIT:
  - mem_rd and mem_addr held.
  - Decrement the counter each edge.
  - At counter==0: capture mem_rdata[7:0], go to LOAD.
- LOAD: pc_write=1, pc_value = {zeros, byte}; go to DONE.
- DONE: done=1; go to IDLE.
- Latency:
  - Request edge to pc_write cycle = 3+MEM_LAT cycles.
  - busy is high for 4+MEM_LAT cycles.
- Signal hold rules:
  - epc_value and cause stay stable from CAPTURE until the next accepted request.
  - pc_value stays stable until the next LOAD.
- exc_req while busy (including the DONE cycle): ignored, not queued. A request still asserted in IDLE after DONE starts a new sequence.
- Simultaneous causes: lowest index wins; the other bits are dropped.
- Reset mid-sequence: next state is IDLE, all outputs are 0, and no pc_write is issued.
- mem_addr addition wraps modulo 2^DATA_W.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - cause constants CAUSE_INVOP=0, CAUSE_OVF=1, CAUSE_DIVZ=2;
  - the exc_state_t encoding;
  - the default VEC_BASE.
- One natural sub-module: exc_prio_enc, a parametrised lowest-index-wins priority encoder with a valid output.

Test Plan:
- Overflow, MEM_LAT=1:
  - Stimulus: exc_req=3'b010, pc_in=32'h0000_0020, mem_rdata[7:0]=8'h80.
  - Response: next cycle epc_write=1 with epc_value=32'h1C; mem_rd=1 with mem_addr=254 for 2 cycles; pc_write=1 with pc_value=32'h80 on cycle 4; done on cycle 5.
- Priority:
  - Stimulus: exc_req=3'b110 (overflow and div-zero together).
  - Response: cause=1, mem_addr=254. A repeat with 3'b101 gives cause=0 and mem_addr=253.
- MEM_LAT=0 and MEM_LAT=3 builds:
  - Stimulus: same divide-by-zero request (exc_req=3'b100) in each build.
  - Response: pc_write is asserted 3 and 6 cycles after the request edge respectively; mem_addr=255.
- Request while busy:
  - Stimulus: pulse exc_req=3'b001 during WAIT.
  - Response: no effect; cause stays 1 and exactly one done pulse occurs.
- Reset in WAIT:
  - Stimulus: assert reset in WAIT.
  - Response: next cycle all outputs are 0 and the block is in IDLE. No pc_write occurs, and the next request runs the full sequence normally.
- PC wrap:
  - Stimulus: pc_in=0.
  - Response: epc_value=32'hFFFF_FFFC.
